// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit samples from an asynchronous codec
// stream and emits one SRAM write strobe per sample, with pause/resume/stop control.
module aud_recorder #(
   parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_stop,
   input  logic        i_aud_bclk,
   input  logic        i_aud_lrc,
   input  logic        i_aud_adcdat,
   output logic [19:0] o_address,
   output logic [15:0] o_data,
   output logic        o_valid,
   output logic        o_busy,
   output logic [19:0] o_last_addr,
   output logic        o_full
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_LRC = 3'd1;
   localparam logic [2:0] SKIP     = 3'd2;
   localparam logic [2:0] SHIFT    = 3'd3;
   localparam logic [2:0] WRITE    = 3'd4;
   localparam logic [2:0] PAUSED   = 3'd5;

   logic [2:0]  state_r;
   logic [2:0]  state_nx_s;
   logic [1:0]  bclk_sync_r;
   logic [1:0]  lrc_sync_r;
   logic [1:0]  adc_sync_r;
   logic        bclk_prev_r;
   logic        lrc_prev_r;
   logic        bclk_rise_s;
   logic        lrc_fall_s;
   logic [3:0]  bit_cnt_r;
   logic [15:0] sample_r;
   logic [15:0] shift_nx_s;

   assign bclk_rise_s = bclk_sync_r[1] & ~bclk_prev_r;
   assign lrc_fall_s  = ~lrc_sync_r[1] & lrc_prev_r;
   assign shift_nx_s  = {sample_r[14:0], adc_sync_r[1]};

   // Two-flop synchronizers for the codec pins plus edge-detect history.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_sync_r <= 2'b00;
         lrc_sync_r  <= 2'b00;
         adc_sync_r  <= 2'b00;
         bclk_prev_r <= 1'b0;
         lrc_prev_r  <= 1'b0;
      end else begin
         bclk_sync_r <= {bclk_sync_r[0], i_aud_bclk};
         lrc_sync_r  <= {lrc_sync_r[0], i_aud_lrc};
         adc_sync_r  <= {adc_sync_r[0], i_aud_adcdat};
         bclk_prev_r <= bclk_sync_r[1];
         lrc_prev_r  <= lrc_sync_r[1];
      end
   end

   // Next-state selection; stop outranks pause, pause outranks start.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (!i_stop && !i_pause && i_start) state_nx_s = WAIT_LRC;
            else                                state_nx_s = IDLE;
         end
         WAIT_LRC: begin
            if (i_stop)          state_nx_s = IDLE;
            else if (i_pause)    state_nx_s = PAUSED;
            else if (lrc_fall_s) state_nx_s = SKIP;
            else                 state_nx_s = WAIT_LRC;
         end
         SKIP: begin
            if (i_stop)           state_nx_s = IDLE;
            else if (i_pause)     state_nx_s = PAUSED;
            else if (bclk_rise_s) state_nx_s = SHIFT;
            else                  state_nx_s = SKIP;
         end
         SHIFT: begin
            if (i_stop)                                  state_nx_s = IDLE;
            else if (i_pause)                            state_nx_s = PAUSED;
            else if (bclk_rise_s && bit_cnt_r == 4'd15)  state_nx_s = WRITE;
            else                                         state_nx_s = SHIFT;
         end
         WRITE: begin
            // The strobe is already on the bus; control pulses only steer where we go next.
            if (o_address == MAX_ADDR) state_nx_s = IDLE;
            else if (i_stop)           state_nx_s = IDLE;
            else if (i_pause)          state_nx_s = PAUSED;
            else                       state_nx_s = WAIT_LRC;
         end
         PAUSED: begin
            if (i_stop)       state_nx_s = IDLE;
            else if (i_pause) state_nx_s = PAUSED;
            else if (i_start) state_nx_s = WAIT_LRC;
            else              state_nx_s = PAUSED;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register with registered busy/valid derived from the next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
         o_busy  <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         o_busy  <= (state_nx_s != IDLE);
         o_valid <= (state_nx_s == WRITE);
      end
   end

   // Sample assembly, write data and address bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_r   <= 4'd0;
         sample_r    <= 16'd0;
         o_data      <= 16'd0;
         o_address   <= 20'd0;
         o_last_addr <= 20'd0;
         o_full      <= 1'b0;
      end else begin
         if (state_r != SHIFT)  bit_cnt_r <= 4'd0;
         else if (bclk_rise_s)  bit_cnt_r <= bit_cnt_r + 4'd1;
         else                   bit_cnt_r <= bit_cnt_r;
         if (state_r == SHIFT && bclk_rise_s) sample_r <= shift_nx_s;
         if (state_nx_s == WRITE)             o_data   <= shift_nx_s;
         if (state_r == IDLE && state_nx_s == WAIT_LRC) begin
            o_address <= 20'd0;
            o_full    <= 1'b0;
         end else if (state_r == WRITE) begin
            o_last_addr <= o_address;
            if (o_address == MAX_ADDR) o_full    <= 1'b1;
            else                       o_address <= o_address + 20'd1;
         end
      end
   end

endmodule

// File: tb/tb_aud_recorder.sv
// Self-checking bench for aud_recorder: drives a bit-banged I2S stream and compares
// the write strobes against a queue-based model of the recording session.
module tb_aud_recorder;

   localparam int HB = 37;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start, pause, stop, bclk, lrc, adc, sel_m;
   logic [19:0] d_addr, d_last, x_addr, x_last;
   logic [15:0] d_data, x_data;
   logic        d_valid, d_busy, d_full, x_valid, x_busy, x_full;
   logic [19:0] obs_addr, obs_last;
   logic [15:0] obs_data;
   logic        obs_valid, obs_busy, obs_full;

   logic [1:0]  m_state;
   logic [19:0] m_addr, m_last, m_max;
   logic        m_full;
   logic [35:0] exp_q[$];
   logic [35:0] obs_q[$];
   logic [58:0] snap;
   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   aud_recorder dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
      .i_aud_bclk(bclk), .i_aud_lrc(lrc), .i_aud_adcdat(adc),
      .o_address(d_addr), .o_data(d_data), .o_valid(d_valid), .o_busy(d_busy),
      .o_last_addr(d_last), .o_full(d_full));

   aud_recorder #(.MAX_ADDR(20'd3)) dut_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
      .i_aud_bclk(bclk), .i_aud_lrc(lrc), .i_aud_adcdat(adc),
      .o_address(x_addr), .o_data(x_data), .o_valid(x_valid), .o_busy(x_busy),
      .o_last_addr(x_last), .o_full(x_full));

   assign obs_addr  = sel_m ? x_addr  : d_addr;
   assign obs_data  = sel_m ? x_data  : d_data;
   assign obs_valid = sel_m ? x_valid : d_valid;
   assign obs_busy  = sel_m ? x_busy  : d_busy;
   assign obs_last  = sel_m ? x_last  : d_last;
   assign obs_full  = sel_m ? x_full  : d_full;

   // Every cycle the strobe is seen high becomes one observed write.
   always @(negedge clk) if (obs_valid === 1'b1) obs_q.push_back({obs_addr, obs_data});

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic void model_reset(input logic [19:0] mx);
      m_state = 2'd0; m_addr = 20'd0; m_last = 20'd0; m_full = 1'b0; m_max = mx;
   endfunction

   // 0 = idle, 1 = recording, 2 = paused
   function automatic void apply_ctl(input logic s, input logic p, input logic t);
      if (t) m_state = 2'd0;
      else if (p) begin
         if (m_state == 2'd1) m_state = 2'd2;
      end else if (s) begin
         if (m_state == 2'd0) begin
            m_state = 2'd1; m_addr = 20'd0; m_full = 1'b0;
         end else if (m_state == 2'd2) m_state = 2'd1;
      end
   endfunction

   task automatic ctl(input logic s, input logic p, input logic t);
      @(negedge clk); start = s; pause = p; stop = t;
      @(negedge clk); start = 1'b0; pause = 1'b0; stop = 1'b0;
      apply_ctl(s, p, t);
      repeat (2) @(negedge clk);
   endtask

   // evt = {reset, stop, pause, start}, fired just after data bit evt_bit rises.
   task automatic do_event(input logic [3:0] evt);
      if (evt[3]) begin
         #2; rst_n = 1'b0; #1;
         snap = {obs_addr, obs_data, obs_valid, obs_busy, obs_last, obs_full};
         model_reset(m_max);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
      end else begin
         @(negedge clk); start = evt[0]; pause = evt[1]; stop = evt[2];
         @(negedge clk); start = 1'b0; pause = 1'b0; stop = 1'b0;
         apply_ctl(evt[0], evt[1], evt[2]);
      end
   endtask

   task automatic send_frame(input logic [15:0] left, input int evt_bit, input logic [3:0] evt);
      logic cap;
      cap = (m_state == 2'd1);
      lrc = 1'b0; #(HB);
      bclk = 1'b1; #(HB); bclk = 1'b0; adc = left[15]; #(HB);
      for (int i = 0; i < 16; i++) begin
         bclk = 1'b1; #(HB);
         if (i + 1 == evt_bit) begin
            do_event(evt);
            cap = cap && (m_state == 2'd1);
         end
         bclk = 1'b0;
         if (i < 15) adc = left[14-i];
         else        adc = 1'($urandom);
         #(HB);
      end
      bclk = 1'b1; #(HB); bclk = 1'b0; adc = 1'($urandom); #(HB);
      lrc = 1'b1;
      for (int i = 0; i < 18; i++) begin
         bclk = 1'b1; #(HB); bclk = 1'b0; adc = 1'($urandom); #(HB);
      end
      if (cap) begin
         exp_q.push_back({m_addr, left});
         m_last = m_addr;
         if (m_addr == m_max) begin
            m_full = 1'b1; m_state = 2'd0;
         end else m_addr = m_addr + 20'd1;
      end
   endtask

   task automatic test_reset();
      start = 1'b0; pause = 1'b0; stop = 1'b0; bclk = 1'b0; lrc = 1'b1; adc = 1'b0; sel_m = 1'b0;
      #2; rst_n = 1'b0; #21;
      n_checks++;
      if ({obs_addr, obs_data, obs_valid, obs_busy, obs_last, obs_full} !== 59'd0)
         $display("FAIL reset_outputs got %h exp 0", {obs_addr, obs_data, obs_valid, obs_busy, obs_last, obs_full});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1; model_reset(20'hFFFFF);
      repeat (4) @(negedge clk);
      n_checks++;
      if (obs_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", obs_busy); else n_pass++;
   endtask

   task automatic test_basic();
      logic [35:0] o, e;
      ctl(1'b1, 1'b0, 1'b0);
      send_frame(16'hA5C3, 0, 4'd0);
      send_frame(16'h0001, 0, 4'd0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL basic_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
      n_checks++;
      if ({obs_last, obs_addr, obs_busy} !== {20'd1, 20'd2, 1'b1})
         $display("FAIL basic_state got last=%0d addr=%0d busy=%b exp 1 2 1", obs_last, obs_addr, obs_busy);
      else n_pass++;
   endtask

   task automatic test_pause();
      logic [35:0] o, e;
      send_frame(16'($urandom), 8, 4'b0010);
      n_checks++;
      if ({obs_busy, obs_addr} !== {1'b1, 20'd2}) $display("FAIL pause_hold got busy=%b addr=%0d exp 1 2", obs_busy, obs_addr); else n_pass++;
      ctl(1'b1, 1'b0, 1'b0);
      send_frame(16'h7FFF, 0, 4'd0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL pause_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL pause_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
      n_checks++;
      if (obs_last !== 20'd2) $display("FAIL pause_last got %0d exp 2", obs_last); else n_pass++;
   endtask

   task automatic test_stop();
      logic [35:0] o, e;
      send_frame(16'($urandom), 0, 4'd0);
      send_frame(16'($urandom), 0, 4'd0);
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      apply_ctl(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", obs_busy); else n_pass++;
      n_checks++;
      if (obs_last !== 20'd4) $display("FAIL stop_last got %0d exp 4", obs_last); else n_pass++;
      send_frame(16'($urandom), 0, 4'd0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL stop_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL stop_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_priority();
      logic [35:0] o, e;
      ctl(1'b1, 1'b0, 1'b0);
      send_frame(16'($urandom), 6, 4'b0110);
      n_checks++;
      if (obs_busy !== 1'b0) $display("FAIL prio_stop_pause got busy=%b exp 0", obs_busy); else n_pass++;
      ctl(1'b1, 1'b0, 1'b0);
      send_frame(16'($urandom), 5, 4'b0010);
      ctl(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_busy !== 1'b1) $display("FAIL prio_start_pause got busy=%b exp 1", obs_busy); else n_pass++;
      send_frame(16'($urandom), 0, 4'd0);
      ctl(1'b1, 1'b0, 1'b0);
      send_frame(16'($urandom), 0, 4'd0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL prio_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL prio_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
      n_checks++;
      if (obs_addr !== m_addr) $display("FAIL prio_addr got %0d exp %0d", obs_addr, m_addr); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [35:0] o, e;
      send_frame(16'($urandom), 9, 4'b1000);
      n_checks++;
      if (snap !== 59'd0) $display("FAIL midreset_outputs got %h exp 0", snap); else n_pass++;
      send_frame(16'($urandom), 0, 4'd0);
      n_checks++;
      if (obs_busy !== 1'b0) $display("FAIL midreset_busy got %b exp 0", obs_busy); else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL midreset_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL midreset_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_full();
      logic [35:0] o, e;
      sel_m = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk); rst_n = 1'b1;
      model_reset(20'd3);
      obs_q.delete(); exp_q.delete();
      ctl(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_frame(16'($urandom), 0, 4'd0);
      n_checks++;
      if (obs_q.size() != 4) $display("FAIL full_count got %0d exp 4", obs_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL full_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
      n_checks++;
      if ({obs_full, obs_busy, obs_addr, obs_last} !== {1'b1, 1'b0, 20'd3, 20'd3})
         $display("FAIL full_state got full=%b busy=%b addr=%0d last=%0d exp 1 0 3 3", obs_full, obs_busy, obs_addr, obs_last);
      else n_pass++;
      ctl(1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({obs_full, obs_busy, obs_addr} !== {1'b0, 1'b1, 20'd0})
         $display("FAIL full_restart got full=%b busy=%b addr=%0d exp 0 1 0", obs_full, obs_busy, obs_addr);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [35:0] o, e;
      logic [2:0]  c;
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            c = 3'($urandom);
            ctl(c[0], c[1], c[2]);
         end
         if ($urandom_range(0, 4) == 0)
            send_frame(16'($urandom), $urandom_range(1, 15), {1'b0, 3'($urandom_range(1, 7))});
         else
            send_frame(16'($urandom), 0, 4'd0);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL random_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL random_write got %h exp %h", o, e); else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
      n_checks++;
      if ({obs_full, obs_busy, obs_addr, obs_last} !== {m_full, (m_state != 2'd0), m_addr, m_last})
         $display("FAIL random_state got full=%b busy=%b addr=%0d last=%0d exp %b %b %0d %0d",
                  obs_full, obs_busy, obs_addr, obs_last, m_full, (m_state != 2'd0), m_addr, m_last);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_stop();
      test_priority();
      test_reset_mid();
      test_full();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
